// File: rtl/cpu_defs.sv
// Shared CPU definitions for the sequential divider: op codes, FSM states,
// and the mapping from ALU instruction indices to divider op codes.
package cpu_defs;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // ALU instruction indices 14..17 map in order onto DIV, DIVU, REM, REMU.
  localparam logic [4:0] ALU_IDX_DIV  = 5'd14;
  localparam logic [4:0] ALU_IDX_DIVU = 5'd15;
  localparam logic [4:0] ALU_IDX_REM  = 5'd16;
  localparam logic [4:0] ALU_IDX_REMU = 5'd17;

  function automatic div_op_e alu_idx_to_div_op(input logic [4:0] idx);
    logic [4:0] rel;
    rel = idx - ALU_IDX_DIV;
    return div_op_e'(rel[1:0]);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a start/done
// handshake and fixed latency; divide-by-zero and signed overflow finish early.
module riscv_seq_divider
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  div_op_e          op_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] divisor_q, rem_q, quo_q, result_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;

  logic             signed_req, a_neg, b_neg, div_zero, sgn_ovf;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix;

  // Request decode: operand magnitudes and early-exit detection.
  always_comb begin
    signed_req = is_signed_op(i_op);
    a_neg      = signed_req & i_dividend[WIDTH-1];
    b_neg      = signed_req & i_divisor[WIDTH-1];
    abs_a      = a_neg ? -i_dividend : i_dividend;
    abs_b      = b_neg ? -i_divisor  : i_divisor;
    div_zero   = (i_divisor == '0);
    sgn_ovf    = signed_req && (i_dividend == MIN_NEG) && (i_divisor == '1);
  end

  // One restoring step; trial carries an extra bit so its sign is the borrow.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    cnt_d     = cnt_q + CNT_W'(1);
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    quo_fix = (is_signed_op(op_q) && (sa_q != sb_q)) ? -quo_q : quo_q;
    rem_fix = (is_signed_op(op_q) && sa_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      op_q      <= DIV_OP_DIV;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            op_q      <= div_op_e'(i_op);
            sa_q      <= a_neg;
            sb_q      <= b_neg;
            divisor_q <= abs_b;
            quo_q     <= abs_a;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (div_zero) begin
              result_q <= is_rem_op(i_op) ? i_dividend : '1;
              done_q   <= 1'b1;
            end else if (sgn_ovf) begin
              result_q <= is_rem_op(i_op) ? '0 : MIN_NEG;
              done_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) state_q <= FIX;
        end
        FIX: begin
          result_q <= is_rem_op(op_q) ? rem_fix : quo_fix;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_riscv_seq_divider.sv
// Scoreboard bench for riscv_seq_divider: directed vectors push expected
// result and done cycle; a negedge monitor checks done, result, hold and busy.
module tb_riscv_seq_divider;
  import cpu_defs::*;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result;

  riscv_seq_divider #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op       (op),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          n;
    bit          special;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_result = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: expected busy is derived from the accept cycles still outstanding.
  always @(negedge clk) begin
    if (!rst) begin
      logic busy_exp;
      exp_t e;
      busy_exp = 1'b0;
      foreach (sb[k])
        if (!sb[k].special && cyc >= sb[k].n && cyc <= sb[k].n + WIDTH) busy_exp = 1'b1;
      n_cmp++;
      if (busy !== busy_exp) begin
        n_fail++;
        $display("FAIL busy at cyc %0d: got %0b want %0b", cyc, busy, busy_exp);
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_done at cyc %0d: result %h, no request outstanding", cyc, result);
        end else begin
          int want_cyc;
          e = sb.pop_front();
          want_cyc = e.n + (e.special ? 0 : WIDTH + 1);
          if (result !== e.exp) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", e.name, result, e.exp);
          end
          n_cmp++;
          if (cyc != want_cyc) begin
            n_fail++;
            $display("FAIL %s latency: done at cyc %0d want %0d", e.name, cyc, want_cyc);
          end
          $display("done %-12s result=%h exp=%h accept=%0d done=%0d", e.name, result, e.exp, e.n, cyc);
          last_result = e.exp;
        end
      end else begin
        n_cmp++;
        if (result !== last_result) begin
          n_fail++;
          $display("FAIL hold at cyc %0d: result %h want %h", cyc, result, last_result);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special, input string name);
    exp_t e;
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.exp = exp;
    e.n = cyc + 1;
    e.special = special;
    e.name = name;
    sb.push_back(e);
    n_vec++;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d request(s) without done", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: busy=%b done=%b result=%h want 0/0/0", name, busy, done, result);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    issue(DIV_OP_DIV,  32'd100,       32'd7,         32'd14,        1'b0, "div_100_7");   drain();
    issue(DIV_OP_REM,  32'd100,       32'd7,         32'd2,         1'b0, "rem_100_7");   drain();
    issue(DIV_OP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, "div_m7_2");    drain();
    issue(DIV_OP_REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0, "rem_m7_2");    drain();
    issue(DIV_OP_REMU, 32'hFFFFFFF9,  32'd2,         32'd1,         1'b0, "remu_big_2");  drain();
    issue(DIV_OP_DIVU, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, "divu_max_1");  drain();
    issue(DIV_OP_DIV,  32'h80000000,  32'd2,         32'hC0000000,  1'b0, "div_min_2");   drain();
    issue(DIV_OP_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, "divu_min_m1"); drain();
    issue(DIV_OP_REMU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, "remu_min_m1"); drain();
    issue(DIV_OP_DIV,  32'h1234,      32'd0,         32'hFFFFFFFF,  1'b1, "div_by0");     drain();
    issue(DIV_OP_DIVU, 32'h1234,      32'd0,         32'hFFFFFFFF,  1'b1, "divu_by0");    drain();
    issue(DIV_OP_REM,  32'h1234,      32'd0,         32'h1234,      1'b1, "rem_by0");     drain();
    issue(DIV_OP_REMU, 32'h1234,      32'd0,         32'h1234,      1'b1, "remu_by0");    drain();
    issue(DIV_OP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1, "div_ovf");     drain();
    issue(DIV_OP_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b1, "rem_ovf");     drain();

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(DIV_OP_DIV, 32'd1000, 32'd10, 32'd100, 1'b0, "busy_div");
    repeat (4) @(negedge clk);
    op = DIV_OP_DIVU; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 60 && done !== 1'b1; t++) @(negedge clk);
    issue(DIV_OP_REM, 32'd1000, 32'd7, 32'd6, 1'b0, "b2b_rem");
    drain();

    // Reset in the middle of CALC aborts with no done.
    issue(DIV_OP_DIV, 32'd50, 32'd5, 32'd10, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_op");
    sb.delete();
    last_result = '0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b0, "after_rst");
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
